// File: rtl/pattern_gen_if.sv
// Video output bundle from pattern_gen towards the DVI encoder; all fields are mutually aligned.
interface pattern_gen_if #(
  parameter int COLOR_W = 8,
  parameter int HC_W    = 10,
  parameter int VC_W    = 10
);
  logic               hsync_o;
  logic               vsync_o;
  logic               de_o;
  logic [COLOR_W-1:0] r_o;
  logic [COLOR_W-1:0] g_o;
  logic [COLOR_W-1:0] b_o;
  logic [HC_W-1:0]    hcount_o;
  logic [VC_W-1:0]    vcount_o;
  logic               sof_o;

  modport master (
    output hsync_o, vsync_o, de_o, r_o, g_o, b_o, hcount_o, vcount_o, sof_o
  );

  modport slave (
    input  hsync_o, vsync_o, de_o, r_o, g_o, b_o, hcount_o, vcount_o, sof_o
  );
endinterface

// File: rtl/pattern_gen.sv
// Video timing + test-pattern source (bars, scrolling ramp, checkerboard, RGB ramp), pattern chosen per frame.
// Fixed 2-cycle latency from counter state to outputs; free-running, no backpressure; rst_n_i is released synchronously upstream.
module pattern_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int COLOR_W   = 8,
  parameter int CHK_LOG2  = 5
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [1:0]    mode_i,
  pattern_gen_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int BS_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HC_W-1:0]    H_LAST  = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0]    H_ACT   = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0]    HS_BEG  = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0]    HS_LAST = HC_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VC_W-1:0]    V_LAST  = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0]    V_ACT   = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0]    VS_BEG  = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0]    VS_LAST = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [BS_W-1:0]    BS_LAST = BS_W'(BAR_W - 1);
  localparam logic [COLOR_W-1:0] FULL    = '1;
  localparam logic               HS_ON   = (HSYNC_POL != 0);
  localparam logic               VS_ON   = (VSYNC_POL != 0);

  logic [HC_W-1:0]    h_cnt_q, h_cnt_d;
  logic [VC_W-1:0]    v_cnt_q, v_cnt_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [2:0]         bar_idx_q, bar_idx_d;
  logic [BS_W-1:0]    bar_sub_q, bar_sub_d;
  logic [1:0]         active_mode_q, active_mode_d;

  logic               s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_sof_q, s1_sof_d;
  logic [COLOR_W-1:0] s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
  logic [HC_W-1:0]    s1_hc_q, s1_hc_d;
  logic [VC_W-1:0]    s1_vc_q, s1_vc_d;

  logic               hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, sof_q, sof_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [HC_W-1:0]    hcount_q, hcount_d;
  logic [VC_W-1:0]    vcount_q, vcount_d;

  logic               frame_start, active;
  logic [1:0]         mode_cur;
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

  always_comb begin
    // The first pixel of a frame already uses the freshly sampled mode, so frames are never split.
    frame_start   = (h_cnt_q == '0) && (v_cnt_q == '0);
    mode_cur      = frame_start ? mode_i : active_mode_q;
    active_mode_d = mode_cur;
    frame_cnt_d   = frame_cnt_q;
    h_cnt_d       = h_cnt_q + 1'b1;
    v_cnt_d       = v_cnt_q;
    bar_sub_d     = bar_sub_q + 1'b1;
    bar_idx_d     = bar_idx_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d   = '0;
      bar_sub_d = '0;
      bar_idx_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d     = '0;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        v_cnt_d = v_cnt_q + 1'b1;
      end
    end else if (bar_sub_q == BS_LAST) begin
      bar_sub_d = '0;
      bar_idx_d = bar_idx_q + 3'd1;
    end

    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (mode_cur)
      2'd0: begin
        pix_r = bar_idx_q[1] ? '0 : FULL;
        pix_g = bar_idx_q[2] ? '0 : FULL;
        pix_b = bar_idx_q[0] ? '0 : FULL;
      end
      2'd1: begin
        pix_r = COLOR_W'(h_cnt_q) + COLOR_W'(frame_cnt_q);
        pix_g = pix_r;
        pix_b = pix_r;
      end
      2'd2: begin
        pix_r = (h_cnt_q[CHK_LOG2] ^ v_cnt_q[CHK_LOG2]) ? FULL : '0;
        pix_g = pix_r;
        pix_b = pix_r;
      end
      default: begin
        pix_r = COLOR_W'(v_cnt_q);
        pix_g = COLOR_W'(h_cnt_q);
        pix_b = FULL - pix_r;
      end
    endcase

    active   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    s1_de_d  = active;
    s1_hs_d  = (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_LAST);
    s1_vs_d  = (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_LAST);
    s1_sof_d = frame_start;
    s1_hc_d  = h_cnt_q;
    s1_vc_d  = v_cnt_q;
    s1_r_d   = active ? pix_r : '0;
    s1_g_d   = active ? pix_g : '0;
    s1_b_d   = active ? pix_b : '0;

    hsync_d  = s1_hs_q ? HS_ON : ~HS_ON;
    vsync_d  = s1_vs_q ? VS_ON : ~VS_ON;
    de_d     = s1_de_q;
    sof_d    = s1_sof_q;
    r_d      = s1_r_q;
    g_d      = s1_g_q;
    b_d      = s1_b_q;
    hcount_d = s1_hc_q;
    vcount_d = s1_vc_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_cnt_q   <= '0;
      bar_idx_q     <= '0;
      bar_sub_q     <= '0;
      active_mode_q <= '0;
      s1_de_q       <= 1'b0;
      s1_hs_q       <= 1'b0;
      s1_vs_q       <= 1'b0;
      s1_sof_q      <= 1'b0;
      s1_r_q        <= '0;
      s1_g_q        <= '0;
      s1_b_q        <= '0;
      s1_hc_q       <= '0;
      s1_vc_q       <= '0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      de_q          <= 1'b0;
      sof_q         <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      bar_idx_q     <= bar_idx_d;
      bar_sub_q     <= bar_sub_d;
      active_mode_q <= active_mode_d;
      s1_de_q       <= s1_de_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      s1_sof_q      <= s1_sof_d;
      s1_r_q        <= s1_r_d;
      s1_g_q        <= s1_g_d;
      s1_b_q        <= s1_b_d;
      s1_hc_q       <= s1_hc_d;
      s1_vc_q       <= s1_vc_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      sof_q         <= sof_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
    end
  end

  assign vid.hsync_o  = hsync_q;
  assign vid.vsync_o  = vsync_q;
  assign vid.de_o     = de_q;
  assign vid.sof_o    = sof_q;
  assign vid.r_o      = r_q;
  assign vid.g_o      = g_q;
  assign vid.b_o      = b_q;
  assign vid.hcount_o = hcount_q;
  assign vid.vcount_o = vcount_q;
endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen on a shrunken 20x12 raster so that >256 frames fit in a short run.
`timescale 1ns/1ps
module tb_pattern_gen;
  localparam int HA = 16, HF = 1, HS = 2, HB = 1;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int HC_W = $clog2(HT);
  localparam int VC_W = $clog2(VT);

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [1:0] mode_i;

  pattern_gen_if #(.COLOR_W(8), .HC_W(HC_W), .VC_W(VC_W)) vid ();

  pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(0), .VSYNC_POL(0), .COLOR_W(8), .CHK_LOG2(2)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .mode_i  (mode_i),
    .vid     (vid)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic            sof;
    logic            de;
    logic            hs;
    logic            vs;
    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic [23:0]     rgb;
  } out_t;

  typedef struct {
    string name;
    int    at;
    out_t  exp;
  } sb_t;

  typedef struct {
    string      name;
    int         f;
    int         h;
    int         v;
    logic [1:0] mode;
    out_t       exp;
  } vec_t;

  sb_t        sb[$];
  vec_t       tbl[$];
  int         total = 0;
  int         bad = 0;
  int         edge_n = 0;
  logic [1:0] cur_mode;
  out_t       got_now;

  // Output after counting edge n shows raster position n-2.
  always @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) edge_n <= 0;
    else          edge_n <= edge_n + 1;

  assign got_now = {vid.sof_o, vid.de_o, vid.hsync_o, vid.vsync_o,
                    vid.hcount_o, vid.vcount_o, vid.r_o, vid.g_o, vid.b_o};

  function automatic out_t mk_out(input logic sof, input logic de, input logic hs, input logic vs,
                                  input int h, input int v, input logic [23:0] rgb);
    out_t o;
    o.sof = sof;
    o.de  = de;
    o.hs  = hs;
    o.vs  = vs;
    o.hc  = HC_W'(h);
    o.vc  = VC_W'(v);
    o.rgb = rgb;
    return o;
  endfunction

  function automatic int pos(input int f, input int h, input int v);
    return f * FR + v * HT + h;
  endfunction

  task automatic add(input string n, input int f, input int h, input int v, input logic [1:0] m,
                     input logic sof, input logic de, input logic hs, input logic vs,
                     input logic [23:0] rgb);
    vec_t r;
    r.name = n;
    r.f    = f;
    r.h    = h;
    r.v    = v;
    r.mode = m;
    r.exp  = mk_out(sof, de, hs, vs, h, v, rgb);
    tbl.push_back(r);
  endtask

  task automatic cmp(input string n, input out_t got, input out_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got sof=%b de=%b hs=%b vs=%b h=%0d v=%0d rgb=%h, want sof=%b de=%b hs=%b vs=%b h=%0d v=%0d rgb=%h",
               n, got.sof, got.de, got.hs, got.vs, got.hc, got.vc, got.rgb,
               exp.sof, exp.de, exp.hs, exp.vs, exp.hc, exp.vc, exp.rgb);
    end
  endtask

  task automatic push(input string n, input int at, input out_t e);
    sb_t s;
    s.name = n;
    s.at   = at;
    s.exp  = e;
    sb.push_back(s);
  endtask

  task automatic check_out();
    while (sb.size() > 0 && sb[0].at <= edge_n) begin
      sb_t e;
      e = sb.pop_front();
      cmp(e.name, got_now, e.exp);
    end
  endtask

  // Steps negedge by negedge until the counter sits at raster position target.
  task automatic run_until(input int target);
    int guard;
    guard  = 0;
    mode_i = cur_mode;
    while (edge_n < target) begin
      @(negedge clk_i);
      check_out();
      mode_i = cur_mode;
      guard++;
      if (guard > 80000) begin
        total++;
        bad++;
        $display("FAIL run_until: stuck at edge %0d, wanted %0d", edge_n, target);
        break;
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i  = 1'b0;
    mode_i   = 2'd0;
    cur_mode = 2'd0;

    // frame 0, colour bars, sync/porch boundaries (HSYNC/VSYNC active-low)
    add("bar_h0",    0,  0, 0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF);
    add("bar_h1",    0,  1, 0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'hFFFFFF);
    add("bar_h2",    0,  2, 0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'hFFFF00);
    add("bar_h4",    0,  4, 0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h00FFFF);
    add("bar_h6",    0,  6, 0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h00FF00);
    add("bar_h8",    0,  8, 0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'hFF00FF);
    add("bar_h10",   0, 10, 0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'hFF0000);
    add("bar_h12",   0, 12, 0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0000FF);
    add("bar_h14",   0, 14, 0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000);
    add("bar_h15",   0, 15, 0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000);
    add("hfp_h16",   0, 16, 0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000);
    add("hs_h17",    0, 17, 0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    add("hs_h18",    0, 18, 0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    add("hbp_h19",   0, 19, 0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000);
    add("bar_v7",    0,  3, 7, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'hFFFF00);
    add("vfp_v8",    0,  3, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000);
    add("vs_v9",     0,  3, 9, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000);
    add("vs_v10",    0, 18, 10, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
    add("vbp_v11",   0,  0, 11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000);
    // scrolling ramp: value = h + frame
    add("ramp_f1_h0",  1,  0, 0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 24'h010101);
    add("ramp_f1_h10", 1, 10, 0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0B0B0B);
    add("ramp_f1_h15", 1, 15, 7, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 24'h101010);
    add("ramp_f2_h10", 2, 10, 3, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0C0C0C);
    // checkerboard with 4-pixel cells
    add("chk_3_0",   3,  3, 0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000);
    add("chk_4_0",   3,  4, 0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 24'hFFFFFF);
    add("chk_blank", 3, 17, 2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    add("chk_0_4",   3,  0, 4, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 24'hFFFFFF);
    add("chk_4_4",   3,  4, 4, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000);
    // RGB ramp: r = v, g = h, b = FF - v
    add("rgb_15_3",  4, 15, 3, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 24'h030FFC);
    add("rgb_5_7",   4,  5, 7, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0705F8);

    #12;
    cmp("reset_state", got_now, mk_out(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 24'h000000));
    @(negedge clk_i);
    rst_n_i = 1'b1;

    foreach (tbl[i]) begin
      cur_mode = tbl[i].mode;
      run_until(pos(tbl[i].f, tbl[i].h, tbl[i].v));
      push(tbl[i].name, edge_n + 2, tbl[i].exp);
    end

    // mode change in the middle of a frame must wait for the next frame start
    cur_mode = 2'd0;
    run_until(pos(5, 0, 4));
    cur_mode = 2'd2;
    mode_i   = cur_mode;
    push("switch_same_cycle", edge_n + 2, mk_out(1'b0, 1'b1, 1'b1, 1'b1, 0, 4, 24'hFFFFFF));
    run_until(pos(5, 9, 7));
    push("switch_hold_bars", edge_n + 2, mk_out(1'b0, 1'b1, 1'b1, 1'b1, 9, 7, 24'hFF00FF));
    run_until(pos(6, 0, 0));
    push("switch_sof_chk", edge_n + 2, mk_out(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 24'h000000));
    run_until(pos(6, 4, 0));
    push("switch_chk_4_0", edge_n + 2, mk_out(1'b0, 1'b1, 1'b1, 1'b1, 4, 0, 24'hFFFFFF));
    cur_mode = 2'd1;
    run_until(pos(6, 9, 7));
    push("switch_chk_hold", edge_n + 2, mk_out(1'b0, 1'b1, 1'b1, 1'b1, 9, 7, 24'hFFFFFF));

    // frame counter wrap: ramp value modulo 256
    run_until(pos(255, 15, 0));
    push("ramp_f255_h15", edge_n + 2, mk_out(1'b0, 1'b1, 1'b1, 1'b1, 15, 0, 24'h0E0E0E));
    run_until(pos(256, 10, 0));
    push("ramp_f256_h10", edge_n + 2, mk_out(1'b0, 1'b1, 1'b1, 1'b1, 10, 0, 24'h0A0A0A));
    run_until(pos(257, 10, 0));
    push("ramp_f257_h10", edge_n + 2, mk_out(1'b0, 1'b1, 1'b1, 1'b1, 10, 0, 24'h0B0B0B));

    // asynchronous reset in the middle of an active line
    run_until(pos(257, 6, 4));
    cmp("pre_reset_pixel", got_now, mk_out(1'b0, 1'b1, 1'b1, 1'b1, 4, 4, 24'h050505));
    #2 rst_n_i = 1'b0;
    #1 cmp("async_reset", got_now, mk_out(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 24'h000000));
    @(negedge clk_i);
    cur_mode = 2'd3;
    mode_i   = cur_mode;
    rst_n_i  = 1'b1;
    push("rel_edge1", 1, mk_out(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 24'h000000));
    push("rel_sof",   2, mk_out(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 24'h0000FF));
    push("rel_h1",    3, mk_out(1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 24'h0001FF));
    run_until(6);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: %0d expected results never compared", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
